memory_dump_reader: RTL and testbench
=====================================

// Module: memory_dump_reader
// PURPOSE
//  Bus initiator that reads a byte range of global memory back out, the inverse of the
//  boot-time image load that writes code/data segments into memory.
//  - Issues word reads on a MemoryBus-style request/response port (DRAM is the responder).
//  - Serialises each 64-bit word into a ready/valid byte stream for a bench dump/compare
//    sink; the sink checks results after a run.
// PARAMETERS
//  ADDR_WIDTH   21    physical address width (matches phys_memory_address_t)
//  WORD_BYTES   8     bytes per memory word; fixed, data width = 8*WORD_BYTES
//  RSP_TIMEOUT  1024  cycles from request acceptance to response before error
// PORTS
//  clk            in   1             clock, all state on posedge
//  reset          in   1             synchronous, active-high
//  start          in   1             1-cycle pulse; sampled only in IDLE
//  base_addr      in   ADDR_WIDTH    first byte address, any alignment
//  byte_count     in   ADDR_WIDTH    number of bytes to dump
//  busy           out  1             high in every state except IDLE
//  done           out  1             1-cycle pulse at end of operation
//  error          out  1             sticky until next accepted start; set on range/timeout fault
//  mem_req_valid  out  1             read request valid
//  mem_req_addr   out  ADDR_WIDTH    word-aligned address; low 3 bits always 0
//  mem_req_ready  in   1             responder accepts request when valid&&ready
//  mem_rsp_valid  in   1             1-cycle read-data strobe
//  mem_rsp_data   in   64            read data; byte lane k = address word_addr+k
//  out_valid      out  1             byte stream valid
//  out_data       out  8             byte value
//  out_last       out  1             high with the final byte of the range
//  out_ready      in   1             sink accepts byte when out_valid&&out_ready
// BEHAVIOUR
//  Reset values: busy, done, error, mem_req_valid, out_valid, out_last = 0;
//    mem_req_addr, out_data = 0.
//  Reset mid-operation: returns to IDLE next cycle; an outstanding response is ignored.
//  FSM states: IDLE, REQ, WAIT_RSP, STREAM, FINISH.
//  IDLE -> start:
//    - latch cur = {base_addr[20:3], 3'b0}, lane = base_addr[2:0], remaining = byte_count.
//    - byte_count == 0: go to FINISH; no bus request issued.
//    - base_addr + byte_count > 2**ADDR_WIDTH (computed at ADDR_WIDTH+1 bits): set error,
//      go to FINISH; no bus request issued.
//    - otherwise go to REQ.
//  REQ: mem_req_valid = 1 and mem_req_addr = cur, both held stable until mem_req_ready.
//    On handshake go to WAIT_RSP and clear the timeout counter.
//  WAIT_RSP: on mem_rsp_valid, capture the word and go to STREAM.
//    - Responses arriving in any other state are ignored.
//    - Counter reaching RSP_TIMEOUT: set error, go to FINISH.
//  STREAM: out_data = word[8*lane +: 8], out_valid = 1, out_last = (remaining == 1).
//    On each out_ready handshake: lane++, remaining--.
//    - remaining reaches 0: go to FINISH.
//    - lane wraps 7 -> 0: cur += 8, go to REQ.
//    - out_valid/out_data are held stable while out_ready is low.
//  FINISH: done = 1 for exactly 1 cycle, busy drops with it, then IDLE.
//  start pulses outside IDLE are ignored. At most one outstanding read.
//  Throughput: the first byte appears 2 cycles after the response strobe.
//    With zero-wait responder and out_ready tied high: 8 bytes per
//    (req handshake + rsp latency + 8) cycles.
// TESTING
//  T1: DRAM preloaded with 0x0706050403020100 at 0x400, start base=0x400 count=8
//      -> bytes 00..07 in order, out_last on 07, one request, done pulse, error=0.
//  T2: base=0x403 count=7 over words at 0x400/0x408 -> bytes 03..09;
//      requests to 0x400 and 0x408 only; out_last on 09.
//  T3: random out_ready (50%) with 3-cycle rsp latency, count=32
//      -> byte stream identical to memory; data stable while stalled.
//  T4: count=0 -> no mem_req_valid ever, done 1 cycle later.
//      base=0x1FFFF8 count=9 -> error=1, no request, done pulse.
//  T5: responder never answers -> error and done at RSP_TIMEOUT cycles after acceptance;
//      busy then returns to 0.
//  T6: reset asserted in STREAM mid-word -> next cycle all outputs at reset values;
//      a new start then dumps correctly.

Source files
------------

// File: rtl/memory_dump_reader.sv
// Reads a byte range of memory one word at a time and replays it as a ready/valid byte stream.
// First byte 2 cycles after the read strobe; out_ready low holds the current byte and defers the next read.
module memory_dump_reader #(
  parameter int ADDR_WIDTH  = 21,
  parameter int WORD_BYTES  = 8,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     byte_count,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [8*WORD_BYTES-1:0]   mem_rsp_data,
  output logic                      out_valid,
  output logic [7:0]                out_data,
  output logic                      out_last,
  input  logic                      out_ready
);
  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int TMO_W  = $clog2(RSP_TIMEOUT + 1);
  localparam int DATA_W = 8 * WORD_BYTES;
  localparam logic [ADDR_WIDTH:0] ADDR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [LANE_W-1:0]     lane_inc;
  logic [DATA_W-1:0]     word_q, word_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [7:0]            out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   end_addr;

  assign lane_inc = lane_q + LANE_W'(1);
  // One extra bit so a range ending exactly at the top of memory is still legal.
  assign end_addr = {1'b0, base_addr} + {1'b0, byte_count};

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    lane_d      = lane_q;
    word_d      = word_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d  = {base_addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
          lane_d = base_addr[LANE_W-1:0];
          rem_d  = byte_count;
          err_d  = 1'b0;
          if (byte_count == '0) begin
            state_d = S_FINISH;
          end else if (end_addr > ADDR_SPAN) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          word_d  = mem_rsp_data;
          state_d = S_STREAM;
        end else if (tmo_q == TMO_W'(RSP_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_STREAM: begin
        // First cycle in STREAM loads the output register from the captured word.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = word_q[{lane_q, 3'b000} +: 8];
          out_last_d  = (rem_q == ADDR_WIDTH'(1));
        end else if (out_ready) begin
          lane_d = lane_inc;
          rem_d  = rem_q - ADDR_WIDTH'(1);
          if (rem_q == ADDR_WIDTH'(1)) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_FINISH;
          end else if (lane_inc == '0) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cur_d       = cur_q + ADDR_WIDTH'(WORD_BYTES);
            state_d     = S_REQ;
          end else begin
            out_data_d = word_q[{lane_inc, 3'b000} +: 8];
            out_last_d = (rem_q == ADDR_WIDTH'(2));
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign error         = err_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = cur_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_last      = out_last_q;

endmodule

// File: tb/tb_memory_dump_reader.sv
// Directed bench for memory_dump_reader: byte and request scoreboards, DRAM responder model, stall checks.
module tb_memory_dump_reader;
  localparam int AW     = 21;
  localparam int TMO    = 1024;
  localparam int M_NORM = 0;
  localparam int M_NOBUS = 1;
  localparam int M_TMO  = 2;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] base_addr, byte_count;
  logic          busy, done, error;
  logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [AW-1:0] mem_req_addr;
  logic [63:0]   mem_rsp_data;
  logic          out_valid, out_last, out_ready;
  logic [7:0]    out_data;

  always #5 clk = ~clk;

  memory_dump_reader #(.ADDR_WIDTH(AW), .WORD_BYTES(8), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .byte_count(byte_count),
    .busy(busy), .done(done), .error(error),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]    exp_q[$];   // {last, data}
  logic [AW-1:0] req_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory image: every byte holds the low 8 bits of its own address.
  function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
    return a[7:0];
  endfunction

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem_byte(a + AW'(k));
    return w;
  endfunction

  // DRAM responder
  bit          no_answer = 0;
  bit          rand_req_rdy = 0;
  int          rsp_lat = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [63:0] pend_word = '0;
  int          hs_cyc = 0;
  int          rsp_cyc = 0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      if (reset) pend = 0;
      else if (pend) begin
        if (pend_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = pend_word;
          pend          = 0;
          rsp_cyc       = cyc;
        end else pend_cnt--;
      end
      mem_req_ready = rand_req_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_req_valid && mem_req_ready && !reset) begin
        hs_cyc = cyc;
        if (req_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL req_unexpected: got request to 0x%0h, expected none", mem_req_addr);
        end else check("req_addr", 64'(mem_req_addr), 64'(req_q.pop_front()));
        if (!no_answer) begin
          pend      = 1;
          pend_cnt  = rsp_lat;
          pend_word = mem_word(mem_req_addr);
        end
      end
    end
  end

  // Byte sink / monitor
  bit         rand_out_rdy = 0;
  bit         stall_pend = 0;
  logic [8:0] stall_val = '0;
  int         rx_cnt = 0;
  bit         lat_chk = 0;
  bit         prev_ov = 0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_pend) check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, stall_val}));
      stall_pend = 0;
      if (lat_chk && out_valid && !prev_ov) begin
        check("first_byte_latency", 64'(cyc - rsp_cyc), 64'd2);
        lat_chk = 0;
      end
      prev_ov   = out_valid;
      out_ready = rand_out_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL byte_unexpected: got 0x%0h last=%0b, expected no byte", out_data, out_last);
        end else check("byte", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
      end else if (out_valid) begin
        stall_pend = 1;
        stall_val  = {out_last, out_data};
      end
    end
  end

  int done_cnt = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 64'({busy, done, error, mem_req_valid, out_valid, out_last, mem_req_addr, out_data}), 64'd0);
  endtask

  task automatic run(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                     input bit exp_err, input int mode);
    int start_cyc;
    int done_at;
    bit seen;
    int first_w;
    int end_b;
    first_w = int'(base) & ~7;
    end_b   = int'(base) + int'(cnt);
    if (mode == M_NORM) begin
      for (int i = 0; i < int'(cnt); i++)
        exp_q.push_back({(i == int'(cnt) - 1), mem_byte(AW'(int'(base) + i))});
      for (int w = first_w; w < end_b; w += 8) req_q.push_back(AW'(w));
    end else if (mode == M_TMO) begin
      req_q.push_back(AW'(first_w));
    end
    done_cnt   = 0;
    hs_cyc     = -1;
    start      = 1'b1;
    base_addr  = base;
    byte_count = cnt;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    seen    = 0;
    done_at = 0;
    for (int i = 0; i < TMO + 400; i++) begin
      if (done) begin
        seen    = 1;
        done_at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    if (mode == M_NOBUS) check({tag, "_done_delay"}, 64'(done_at - start_cyc), 64'd1);
    // Handshake cycle, then TMO waiting cycles, then the FINISH cycle.
    if (mode == M_TMO) check({tag, "_timeout_cycles"}, 64'(done_at - hs_cyc), 64'(TMO + 1));
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 64'({busy, done}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_error_sticky"}, 64'(error), 64'(exp_err));
    check({tag, "_bytes_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_reqs_left"}, 64'(req_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1000000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    byte_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: aligned single word, also first-byte latency
    lat_chk = 1;
    run("t1", 21'h400, 21'd8, 1'b0, M_NORM);
    check("t1_latency_checked", 64'(lat_chk), 64'd0);

    // T2: unaligned start spanning two words
    run("t2", 21'h403, 21'd7, 1'b0, M_NORM);

    // T3: slow responder, random backpressure, stray start while busy
    rsp_lat      = 3;
    rand_out_rdy = 1;
    rand_req_rdy = 1;
    fork
      run("t3", 21'h40D, 21'd32, 1'b0, M_NORM);
      begin
        repeat (20) @(posedge clk);
        #1;
        start      = 1'b1;
        base_addr  = 21'h000;
        byte_count = 21'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    rsp_lat      = 0;
    rand_out_rdy = 0;
    rand_req_rdy = 0;

    // T4: empty range, range past end of memory, range ending exactly at the top
    run("t4_zero", 21'h400, 21'd0, 1'b0, M_NOBUS);
    run("t4_range", 21'h1FFFF8, 21'd9, 1'b1, M_NOBUS);
    run("t4_top", 21'h1FFFF8, 21'd8, 1'b0, M_NORM);

    // T5: responder never answers
    no_answer = 1;
    run("t5", 21'h400, 21'd8, 1'b1, M_TMO);
    no_answer = 0;

    // T6: reset in the middle of a word
    rx_cnt = 0;
    for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), mem_byte(AW'(32'h400 + i))});
    req_q.push_back(21'h400);
    req_q.push_back(21'h408);
    start      = 1'b1;
    base_addr  = 21'h400;
    byte_count = 21'd16;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rx_cnt >= 3) break;
      @(posedge clk); #1;
    end
    check("t6_mid_word", 64'(rx_cnt >= 3 && out_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t6_reset_values");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    req_q.delete();
    @(posedge clk); #1;
    run("t6_after", 21'h400, 21'd8, 1'b0, M_NORM);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
